nfsr_keystream_ctrl: RTL and testbench
======================================

// Module: nfsr_keystream_ctrl
// PURPOSE
//   Sequencer for the 24-bit nfsr keystream register: latches a seed on start,
//   parallel-loads it, runs a discarded warm-up, then streams NUM_BITS keystream
//   bits to a consumer over a valid/ready handshake.
//   Sits between the cipher top level and the nfsr; sole driver of its Par_load/shift_en/Seed.
// PARAMETERS
//   WIDTH          24   nfsr state width; width of seed_in / nfsr_seed
//   WARMUP_CYCLES  48   shifts discarded after load (0 allowed: skip WARMUP)
//   NUM_BITS       64   keystream bits delivered per run (must be >= 1)
// PORTS
//   clk            in   1      rising-edge clock
//   rst            in   1      synchronous active-high reset
//   start          in   1      begin run; sampled only in IDLE
//   abort          in   1      cancel run; synchronous, any state
//   seed_in        in   WIDTH  seed; captured on the cycle start is accepted
//   ks_ready       in   1      consumer accepts ks_bit this cycle
//   ks_bit         out  1      keystream bit (= nfsr_ser_out in RUN, else 0)
//   ks_valid       out  1      ks_bit valid
//   busy           out  1      high in LOAD, WARMUP, RUN
//   done           out  1      one-cycle pulse after last bit accepted
//   seed_err       out  1      one-cycle pulse, zero seed rejected (macro only)
//   nfsr_par_load  out  1      to nfsr Par_load
//   nfsr_shift_en  out  1      to nfsr shift_en
//   nfsr_seed      out  WIDTH  to nfsr Seed (registered copy of seed_in)
//   nfsr_ser_out   in   1      from nfsr Ser_out
// BEHAVIOUR
//   - Reset: state=IDLE; counters=0; nfsr_seed=0; all 1-bit outputs 0.
//   - rst takes priority over abort; abort over start and all transitions.
//   - IDLE: start=1 -> capture seed_in into nfsr_seed, go LOAD. No other output.
//   - LOAD (1 cycle): nfsr_par_load=1, nfsr_shift_en=0.
//     Next: WARMUP if WARMUP_CYCLES>0, else RUN.
//   - WARMUP: nfsr_shift_en=1 for exactly WARMUP_CYCLES consecutive cycles.
//     ks_valid=0. Then RUN.
//   - RUN: ks_valid=1; ks_bit=nfsr_ser_out (combinational pass-through).
//     nfsr_shift_en=ks_ready.
//     Handshake = ks_valid&ks_ready; one bit delivered and one nfsr shift per handshake.
//     ks_ready low: no shift; ks_bit holds stable.
//     The NUM_BITS-th handshake -> DONE.
//   - DONE (1 cycle): done=1, ks_valid=0 -> IDLE. start here is ignored.
//   - start while busy or in DONE: ignored; seed not recaptured.
//   - abort in LOAD/WARMUP/RUN/DONE: next cycle IDLE, counters cleared,
//     no done pulse, nfsr_seed retained.
//   - Latency start->first ks_valid: WARMUP_CYCLES+2 cycles
//     (IDLE accept edge, LOAD, WARMUP).
//   - Counters: warm-up counter $clog2(WARMUP_CYCLES+1) bits; bit counter
//     $clog2(NUM_BITS+1) bits. Both clear on entry to LOAD and never wrap
//     within a run.
//   - nfsr_par_load and nfsr_shift_en are never high together.
//   - Mid-run reset: IDLE next cycle, nfsr left unloaded; next start reloads.
// CONFIGURATION
//   NFSR_CTRL_ZERO_SEED_CHK_EN defined:
//     start with seed_in==0 in IDLE is rejected; stay IDLE, seed_err=1 for
//     one cycle, nfsr_seed unchanged.
//   Not defined:
//     seed_err tied 0; zero seed loaded and run normally.
// TESTING
//   Checks use WIDTH=24, WARMUP_CYCLES=4, NUM_BITS=8.
//   1 Reset: rst=1 two cycles -> all outputs 0, nfsr_seed=0, busy=0.
//   2 Normal run: seed 24'habcdef, start 1 cycle, ks_ready=1 ->
//     par_load high 1 cycle; shift_en high 4 cycles, ks_valid=0;
//     8 bits delivered matching reference nfsr model; done pulse; busy=0.
//   3 Back-pressure: ks_ready toggles 1,0,0,1,... in RUN ->
//     shift_en=ks_ready; ks_bit stable while ready=0;
//     exactly 8 handshakes before done.
//   4 Abort: assert abort in 3rd WARMUP cycle ->
//     IDLE next cycle, no done, shift_en=0;
//     new start with 24'h123456 runs clean.
//   5 Start/seed while busy: start=1 with seed 24'h000001 during RUN ->
//     ignored; nfsr_seed stays 24'habcdef; run completes normally.
//   6 Zero seed, macro on: start with 24'h000000 -> seed_err pulse, stays IDLE.
//     Macro off: full run, done pulses.

Source files
------------

// File: rtl/nfsr_keystream_ctrl.sv
// Sequencer for the 24-bit nfsr keystream register: seed capture, parallel load,
// discarded warm-up, then NUM_BITS keystream bits over valid/ready.
// Optional zero-seed rejection is enabled by defining NFSR_CTRL_ZERO_SEED_CHK_EN.
module nfsr_keystream_ctrl #(
    parameter int WIDTH         = 24,
    parameter int WARMUP_CYCLES = 48,
    parameter int NUM_BITS      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             ks_ready,
    output logic             ks_bit,
    output logic             ks_valid,
    output logic             busy,
    output logic             done,
    output logic             seed_err,
    output logic             nfsr_par_load,
    output logic             nfsr_shift_en,
    output logic [WIDTH-1:0] nfsr_seed,
    input  logic             nfsr_ser_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    // A zero-length warm-up still needs a 1-bit counter to stay legal.
    localparam int WC_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam int BC_W = $clog2(NUM_BITS + 1);

    localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(NUM_BITS - 1);

    state_t           state_q, state_d;
    logic [WC_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] seed_q;

    logic seed_zero;
    logic start_acc;
    logic handshake;

`ifdef NFSR_CTRL_ZERO_SEED_CHK_EN
    assign seed_zero = (seed_in == '0);
`else
    assign seed_zero = 1'b0;
`endif

    assign start_acc = (state_q == S_IDLE) && start && !abort && !seed_zero;
    assign handshake = (state_q == S_RUN) && ks_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        if (abort) begin
            state_d    = S_IDLE;
            warm_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        state_d    = S_LOAD;
                        warm_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                S_LOAD: begin
                    if (WARMUP_CYCLES > 0) state_d = S_WARMUP;
                    else                   state_d = S_RUN;
                end
                S_WARMUP: begin
                    // Final value reaches WARMUP_CYCLES, which the counter width holds.
                    warm_cnt_d = warm_cnt_q + 1'b1;
                    if (warm_cnt_q == WARM_LAST) state_d = S_RUN;
                end
                S_RUN: begin
                    if (handshake) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ks_bit        = 1'b0;
        ks_valid      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        nfsr_par_load = 1'b0;
        nfsr_shift_en = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                busy          = 1'b1;
                nfsr_par_load = 1'b1;
            end
            S_WARMUP: begin
                busy          = 1'b1;
                nfsr_shift_en = 1'b1;
            end
            S_RUN: begin
                busy          = 1'b1;
                ks_valid      = 1'b1;
                ks_bit        = nfsr_ser_out;
                nfsr_shift_en = ks_ready;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            seed_q     <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            if (start_acc) seed_q <= seed_in;
        end
    end

    assign nfsr_seed = seed_q;

`ifdef NFSR_CTRL_ZERO_SEED_CHK_EN
    logic seed_err_q;

    always_ff @(posedge clk) begin
        if (rst) seed_err_q <= 1'b0;
        else     seed_err_q <= (state_q == S_IDLE) && start && !abort && seed_zero;
    end

    assign seed_err = seed_err_q;
`else
    assign seed_err = 1'b0;
`endif

endmodule

// File: tb/tb_nfsr_keystream_ctrl.sv
// Scoreboard bench for nfsr_keystream_ctrl with a behavioural nfsr attached.
// Zero-seed expectations follow NFSR_CTRL_ZERO_SEED_CHK_EN as built.
`timescale 1ns/1ps
module tb_nfsr_keystream_ctrl;

    localparam int WIDTH = 24;
    localparam int WARM  = 4;
    localparam int NBITS = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] seed_in;
    logic             ks_ready;
    logic             ks_bit;
    logic             ks_valid;
    logic             busy;
    logic             done;
    logic             seed_err;
    logic             nfsr_par_load;
    logic             nfsr_shift_en;
    logic [WIDTH-1:0] nfsr_seed;
    logic             nfsr_ser_out;

    logic [WIDTH-1:0] nfsr_q = '0;

    int total = 0;
    int bad   = 0;
    bit exp_bits[$];
    int exp_done[$];

    always #5 clk = ~clk;

    nfsr_keystream_ctrl #(
        .WIDTH        (WIDTH),
        .WARMUP_CYCLES(WARM),
        .NUM_BITS     (NBITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .seed_in      (seed_in),
        .ks_ready     (ks_ready),
        .ks_bit       (ks_bit),
        .ks_valid     (ks_valid),
        .busy         (busy),
        .done         (done),
        .seed_err     (seed_err),
        .nfsr_par_load(nfsr_par_load),
        .nfsr_shift_en(nfsr_shift_en),
        .nfsr_seed    (nfsr_seed),
        .nfsr_ser_out (nfsr_ser_out)
    );

    function automatic logic [WIDTH-1:0] nfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = s[0] ^ s[3] ^ s[11] ^ (s[7] & s[16]) ^ (s[20] & s[22]);
        return {fb, s[WIDTH-1:1]};
    endfunction

    // Reference nfsr, driven only by the controller's load/shift strobes.
    always @(posedge clk) begin
        if (nfsr_par_load)      nfsr_q <= nfsr_seed;
        else if (nfsr_shift_en) nfsr_q <= nfsr_step(nfsr_q);
    end
    assign nfsr_ser_out = nfsr_q[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [WIDTH-1:0] seed);
        logic [WIDTH-1:0] s;
        s = seed;
        repeat (WARM) s = nfsr_step(s);
        for (int i = 0; i < NBITS; i++) begin
            exp_bits.push_back(s[0]);
            s = nfsr_step(s);
        end
        exp_done.push_back(1);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0; 2: start with seed 1 during RUN
    task automatic do_run(input logic [WIDTH-1:0] seed, input int mode, input string tag);
        int hs;
        int cyc;
        bit seen_done;
        hs = 0;
        cyc = 0;
        seen_done = 1'b0;
        push_expected(seed);
        tick();
        start = 1'b1; seed_in = seed; ks_ready = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_load_par"}, nfsr_par_load, 1);
        check({tag, "_load_shift"}, nfsr_shift_en, 0);
        check({tag, "_load_busy"}, busy, 1);
        check({tag, "_load_seed"}, nfsr_seed, seed);
        for (int w = 0; w < WARM; w++) begin
            tick();
            check({tag, "_warm_shift"}, nfsr_shift_en, 1);
            check({tag, "_warm_valid"}, ks_valid, 0);
        end
        tick();
        check({tag, "_first_valid"}, ks_valid, 1);
        while (cyc < 100) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            ks_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            if (mode == 2) begin
                start   = (cyc >= 1 && cyc <= 3);
                seed_in = start ? 24'h000001 : seed;
            end
            if (ks_valid && ks_ready) hs++;
            cyc++;
            tick();
        end
        check({tag, "_done_seen"}, seen_done, 1);
        check({tag, "_handshakes"}, hs, NBITS);
        start = 1'b0;
        ks_ready = 1'b1;
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_valid"}, ks_valid, 0);
        check({tag, "_seed_kept"}, nfsr_seed, seed);
    endtask

    // Monitor: consumes expected bits and done pulses as the DUT presents them.
    initial begin : monitor
        logic prev_stall;
        logic prev_bit;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            check("par_load_shift_excl", nfsr_par_load & nfsr_shift_en, 0);
            if (ks_valid) begin
                check("shift_eq_ready", nfsr_shift_en, ks_ready);
                if (prev_stall) check("ks_bit_hold", ks_bit, prev_bit);
                if (ks_ready) begin
                    if (exp_bits.size() == 0) check("bit_expected", ks_valid, 0);
                    else                      check("ks_bit", ks_bit, exp_bits.pop_front());
                end
                prev_stall = !ks_ready;
                prev_bit   = ks_bit;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                if (exp_done.size() == 0) check("done_expected", done, 0);
                else                      check("done_pulse", done, exp_done.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; abort = 1'b0; seed_in = '0; ks_ready = 1'b0;
        tick();
        tick();
        check("rst_ks_bit", ks_bit, 0);
        check("rst_ks_valid", ks_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_seed_err", seed_err, 0);
        check("rst_par_load", nfsr_par_load, 0);
        check("rst_shift_en", nfsr_shift_en, 0);
        check("rst_nfsr_seed", nfsr_seed, 0);
        rst = 1'b0;

        do_run(24'habcdef, 0, "normal");
        do_run(24'h13579b, 1, "backpressure");

        // Abort in the third warm-up cycle
        tick();
        start = 1'b1; seed_in = 24'habcdef;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_pre_shift", nfsr_shift_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_shift", nfsr_shift_en, 0);
        check("abort_done", done, 0);
        check("abort_seed_kept", nfsr_seed, 24'habcdef);
        repeat (3) tick();
        check("abort_stays_idle", busy, 0);

        // Abort beats start in IDLE
        start = 1'b1; abort = 1'b1; seed_in = 24'h777777;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_load", nfsr_par_load, 0);
        check("abort_idle_seed", nfsr_seed, 24'habcdef);

        do_run(24'h123456, 0, "after_abort");
        do_run(24'habcdef, 2, "start_busy");

`ifdef NFSR_CTRL_ZERO_SEED_CHK_EN
        tick();
        start = 1'b1; seed_in = '0;
        tick();
        start = 1'b0;
        check("zero_seed_err", seed_err, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_err_pulse", seed_err, 0);
        check("zero_still_idle", busy, 0);
        check("zero_seed_kept", nfsr_seed, 24'habcdef);
`else
        do_run(24'h000000, 0, "zero_seed");
        check("zero_no_err", seed_err, 0);
`endif

        repeat (3) tick();
        check("bits_drained", exp_bits.size(), 0);
        check("dones_drained", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
